vedic_mul_pipe: RTL and testbench
=================================

VEDIC_MUL_PIPE -- requirements
Module: vedic_mul_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand width; legal values are 2, 4, 8, 16 and 32.
REQ-002 The block SHALL have parameter SIGNED_EN, default 1; when 0, signed mode is disabled and is_signed is ignored.
REQ-003 Port: clk  input  1  clock; all state is updated on the rising edge.
REQ-004 Port: reset  input  1  reset, synchronous, active-high.
REQ-005 Port: a  input  WIDTH  multiplicand, sampled when do=1.
REQ-006 Port: b  input  WIDTH  multiplier, sampled when do=1.
REQ-007 Port: is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with do.
REQ-008 Port: do  input  1  operation request, one operation per cycle.
REQ-009 Port: hold  input  1  stall; freezes the whole pipeline.
REQ-010 Port: result  output  2*WIDTH  product.
REQ-011 Port: done  output  1  one-cycle pulse marking result valid.
REQ-012 Port: busy  output  1  high while any stage holds a valid operation.

Function
REQ-013 The block SHALL compute a*b by Vedic (Urdhva-Tiryagbhyam) recursion: 2x2 leaf cells, with one register level per recursion level.
REQ-014 Latency SHALL be LAT = log2(WIDTH)+2 cycles, broken down as follows:
- stage 0 registers the operand magnitudes and the result sign;
- stages 1..log2(WIDTH) perform leaf products and level-by-level combining;
- the final stage applies sign correction and registers result.
REQ-015 A do sampled at edge N (hold=0) SHALL raise done for exactly the cycle after edge N+LAT-1.
REQ-016 Throughput SHALL be one operation per cycle; back-to-back do operations SHALL produce done on consecutive cycles, in order.
REQ-017 Each stage SHALL carry its own valid bit; done SHALL be the final-stage valid.
REQ-018 The product SHALL be full width with no truncation.
- Unsigned range: 0..(2^WIDTH-1)^2.
- Signed: -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2), which SHALL be exact.
REQ-019 In signed mode the block SHALL convert each operand to its magnitude (-2^(WIDTH-1) maps to its unsigned magnitude), multiply unsigned, and negate when sign(a) XOR sign(b) = 1.
REQ-020 A zero product SHALL yield result 0 regardless of sign.
REQ-021 result SHALL update only when done=1 and SHALL hold its value between done pulses.
REQ-022 While hold=1:
- no stage register, valid bit, result or done SHALL change;
- do SHALL be ignored and the operation lost;
- done held at 1 SHALL remain 1 until hold drops, then pulse exactly once.
REQ-023 On the first cycle with hold=0 the pipeline SHALL resume with no duplicated or dropped in-flight operation.
REQ-024 busy SHALL be the OR of all stage valid bits plus the done register.
REQ-025 do and hold SHALL both be sampled in the same cycle; hold SHALL take priority.

Reset
REQ-026 While reset=1, the block SHALL clear every valid bit, set done=0, busy=0 and result=0; reset SHALL take priority over hold and do.
REQ-027 On reset mid-operation, all in-flight operations SHALL be discarded, and no done SHALL occur for them after reset is released.
REQ-028 The first do sampled on the first edge after reset is released SHALL complete at the normal LAT.

Verification
REQ-029 WIDTH=8, unsigned: a=0xFF, b=0xFF, do for one cycle -> done exactly 5 cycles later, result=0xFE01.
REQ-030 WIDTH=8, signed:
- a=0x80, b=0x80 -> result=0x4000;
- a=0xFF, b=0x01 -> 0xFFFF;
- a=0x00, b=0x80 -> 0x0000.
REQ-031 WIDTH=8, throughput: 4 back-to-back operations (3x5, 7x9, 0x0, 255x1) -> done high 4 consecutive cycles with 15, 63, 0, 255, in order.
REQ-032 WIDTH=8, stall: hold=1 for 3 cycles while 2 operations are in flight -> both results correct, each done delayed by exactly 3 cycles, no extra done pulse.
REQ-033 WIDTH=8, reset: reset asserted 2 cycles after do -> done never rises for that operation, result=0, busy=0; a new do issued after release completes in 5 cycles.
REQ-034 WIDTH=2 and WIDTH=32: exhaustive (2-bit) and 10k random (32-bit) signed/unsigned operands -> all results match the reference model, LAT=3 and LAT=7 respectively.

Source files
------------

// File: rtl/vedic_mul_pipe.sv
// Pipelined Vedic (Urdhva-Tiryagbhyam) multiplier: 2x2 leaf cells, one recursion
// level per register stage, wrapped by magnitude extraction and sign restoration.
module vedic_mul_pipe #(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  input  logic               do_req,   // operation request; "do" is a reserved word
  input  logic               hold,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
  output logic               busy
);
  localparam int LVLS = $clog2(WIDTH);

  function automatic logic [3:0] leaf2x2(input logic [1:0] x, input logic [1:0] y);
    logic cross_a, cross_b, top, carry;
    cross_a = x[1] & y[0];
    cross_b = x[0] & y[1];
    top     = x[1] & y[1];
    carry   = cross_a & cross_b;
    return {top & carry, top ^ carry, cross_a ^ cross_b, x[0] & y[0]};
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] mag,
                                                    input logic neg);
    return neg ? -mag : mag;
  endfunction

  logic               signed_op, neg_in;
  logic [WIDTH-1:0]   mag_a_p0, mag_b_p0;
  logic [LVLS:0]      vld_p, neg_p;

  assign signed_op = (SIGNED_EN != 0) && is_signed;
  assign neg_in    = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);

  // ---- stage 0: operand magnitudes; sign travels alongside valid ----
  always_ff @(posedge clk) begin
    if (!hold) begin
      mag_a_p0 <= (signed_op && a[WIDTH-1]) ? -a : a;
      mag_b_p0 <= (signed_op && b[WIDTH-1]) ? -b : b;
      neg_p    <= {neg_p[LVLS-1:0], neg_in};
    end
  end

  // ---- stages 1..LVLS: leaf products, then one combine level per stage ----
  for (genvar k = 1; k <= LVLS; k++) begin : g_lvl
    localparam int S = 1 << k;
    localparam int N = WIDTH / S;
    logic [2*S-1:0] nxt  [N][N];
    logic [2*S-1:0] prod [N][N];   // prod[i][j] = a-chunk i times b-chunk j

    for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
        if (k == 1) begin : g_leaf
          assign nxt[i][j] = leaf2x2(mag_a_p0[2*i +: 2], mag_b_p0[2*j +: 2]);
        end else begin : g_comb
          localparam int H = S / 2;
          logic [2*S-1:0] hh, hl, lh, ll;
          assign hh = {{S{1'b0}}, g_lvl[k-1].prod[2*i+1][2*j+1]};
          assign hl = {{S{1'b0}}, g_lvl[k-1].prod[2*i+1][2*j]};
          assign lh = {{S{1'b0}}, g_lvl[k-1].prod[2*i][2*j+1]};
          assign ll = {{S{1'b0}}, g_lvl[k-1].prod[2*i][2*j]};
          assign nxt[i][j] = (hh << S) + ((hl + lh) << H) + ll;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!hold) prod <= nxt;
    end
  end

  // ---- control: per-stage valid and done; hold freezes everything ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
      done  <= 1'b0;
    end else if (!hold) begin
      vld_p <= {vld_p[LVLS-1:0], do_req};
      done  <= vld_p[LVLS];
    end
  end

  // ---- final stage: sign correction; result only moves with a new done ----
  always_ff @(posedge clk) begin
    if (reset)
      result <= '0;
    else if (!hold && vld_p[LVLS])
      result <= apply_sign(g_lvl[LVLS].prod[0][0], neg_p[LVLS]);
  end

  assign busy = (|vld_p) | done;

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Bench for vedic_mul_pipe: directed WIDTH=8 vectors, exhaustive WIDTH=2 and
// streamed random WIDTH=32 operands against a behavioural product model.
module tb_vedic_mul_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  a8, b8;
  logic        s8, do8, hold8;
  logic [15:0] res8;
  logic        done8, busy8;
  logic [1:0]  a2, b2;
  logic        s2, do2, hold2;
  logic [3:0]  res2;
  logic        done2, busy2;
  logic [31:0] a32, b32;
  logic        s32, do32, hold32;
  logic [63:0] res32;
  logic        done32, busy32;

  int n_vec = 0;
  int n_err = 0;

  vedic_mul_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .a(a8), .b(b8), .is_signed(s8), .do_req(do8),
    .hold(hold8), .result(res8), .done(done8), .busy(busy8));

  vedic_mul_pipe #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .a(a2), .b(b2), .is_signed(s2), .do_req(do2),
    .hold(hold2), .result(res2), .done(done2), .busy(busy2));

  vedic_mul_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .a(a32), .b(b32), .is_signed(s32), .do_req(do32),
    .hold(hold32), .result(res32), .done(done32), .busy(busy32));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input logic sg);
    longint xv, yv, p;
    logic [63:0] m;
    xv = {32'b0, x};
    yv = {32'b0, y};
    if (sg && x[w-1]) xv -= (longint'(1) << w);
    if (sg && y[w-1]) yv -= (longint'(1) << w);
    p = xv * yv;
    m = (w == 32) ? '1 : ((64'd1 << (2*w)) - 64'd1);
    return 64'(p) & m;
  endfunction

  task automatic drive(input int w, input logic [31:0] x, input logic [31:0] y,
                       input logic sg, input logic d);
    case (w)
      2:       begin a2 = x[1:0]; b2 = y[1:0]; s2 = sg; do2 = d; end
      8:       begin a8 = x[7:0]; b8 = y[7:0]; s8 = sg; do8 = d; end
      default: begin a32 = x; b32 = y; s32 = sg; do32 = d; end
    endcase
  endtask

  function automatic logic get_done(input int w);
    return (w == 2) ? done2 : (w == 8) ? done8 : done32;
  endfunction

  function automatic logic [63:0] get_res(input int w);
    return (w == 2) ? 64'(res2) : (w == 8) ? 64'(res8) : res32;
  endfunction

  // One isolated operation: latency, product, single-cycle pulse, result hold.
  task automatic run_op(input string tag, input int w, input logic [31:0] x,
                        input logic [31:0] y, input logic sg,
                        input logic [63:0] exp, input int lat);
    int cyc;
    @(negedge clk);
    drive(w, x, y, sg, 1'b1);
    @(negedge clk);
    drive(w, 32'd0, 32'd0, 1'b0, 1'b0);
    cyc = 1;
    while (!get_done(w) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, cyc, lat);
    check(tag, get_res(w), exp);
    @(negedge clk);
    check({tag, "_pulse"}, get_done(w), 1'b0);
    check({tag, "_keep"}, get_res(w), exp);
  endtask

  initial begin
    int nd;
    logic [63:0] q[$];
    logic [63:0] e;

    reset = 1'b1;
    a8 = '0; b8 = '0; s8 = 1'b0; do8 = 1'b0; hold8 = 1'b0;
    a2 = '0; b2 = '0; s2 = 1'b0; do2 = 1'b0; hold2 = 1'b0;
    a32 = '0; b32 = '0; s32 = 1'b0; do32 = 1'b0; hold32 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_res8", res8, 16'h0);
    check("rst_done8", done8, 1'b0);
    check("rst_busy8", busy8, 1'b0);
    check("rst_done2", done2, 1'b0);
    check("rst_busy2", busy2, 1'b0);
    check("rst_res32", res32, 64'h0);
    check("rst_busy32", busy32, 1'b0);
    reset = 1'b0;

    run_op("u_ffff", 8, 32'hFF, 32'hFF, 1'b0, 64'hFE01, 5);
    run_op("s_8080", 8, 32'h80, 32'h80, 1'b1, 64'h4000, 5);
    run_op("s_ff01", 8, 32'hFF, 32'h01, 1'b1, 64'hFFFF, 5);
    run_op("s_0080", 8, 32'h00, 32'h80, 1'b1, 64'h0000, 5);
    run_op("s_7f80", 8, 32'h7F, 32'h80, 1'b1, 64'hC080, 5);
    run_op("s_8001", 8, 32'h80, 32'h01, 1'b1, 64'hFF80, 5);
    run_op("s_ffff", 8, 32'hFF, 32'hFF, 1'b1, 64'h0001, 5);
    run_op("u_ff01", 8, 32'hFF, 32'h01, 1'b0, 64'h00FF, 5);
    run_op("u_8080", 8, 32'h80, 32'h80, 1'b0, 64'h4000, 5);

    // back-to-back: dones on four consecutive cycles, in order
    @(negedge clk); a8 = 8'd3;   b8 = 8'd5; s8 = 1'b0; do8 = 1'b1;
    @(negedge clk); a8 = 8'd7;   b8 = 8'd9;
    @(negedge clk); a8 = 8'd0;   b8 = 8'd0;
    @(negedge clk); a8 = 8'd255; b8 = 8'd1;
    @(negedge clk); do8 = 1'b0;
    @(negedge clk); check("tp_done0", done8, 1'b1); check("tp_res0", res8, 16'd15);
    @(negedge clk); check("tp_done1", done8, 1'b1); check("tp_res1", res8, 16'd63);
    @(negedge clk); check("tp_done2", done8, 1'b1); check("tp_res2", res8, 16'd0);
    @(negedge clk); check("tp_done3", done8, 1'b1); check("tp_res3", res8, 16'd255);
    @(negedge clk); check("tp_done_end", done8, 1'b0);
    check("tp_busy_end", busy8, 1'b0);

    // stall with two operations in flight; do during hold must be dropped
    @(negedge clk); a8 = 8'd12;  b8 = 8'd11; s8 = 1'b0; do8 = 1'b1;
    @(negedge clk); a8 = 8'd200; b8 = 8'd3;
    @(negedge clk); a8 = 8'h11;  b8 = 8'h11; hold8 = 1'b1;
    nd = 0;
    for (int c = 3; c <= 14; c++) begin
      @(negedge clk);
      if (c == 4) check("stall_busy", busy8, 1'b1);
      if (done8) begin
        nd++;
        if (nd == 1) begin
          check("stall_cyc1", c, 8);
          check("stall_res1", res8, 16'd132);
        end else if (nd == 2) begin
          check("stall_cyc2", c, 9);
          check("stall_res2", res8, 16'd600);
        end
      end
      if (c == 5) begin hold8 = 1'b0; do8 = 1'b0; end
    end
    check("stall_ndone", nd, 2);

    // hold while done is high: done stays up, then pulses once
    @(negedge clk); a8 = 8'd6; b8 = 8'd7; s8 = 1'b0; do8 = 1'b1;
    @(negedge clk); do8 = 1'b0;
    repeat (4) @(negedge clk);
    check("dh_done0", done8, 1'b1);
    check("dh_res0", res8, 16'd42);
    hold8 = 1'b1;
    @(negedge clk); check("dh_done1", done8, 1'b1);
    @(negedge clk); check("dh_done2", done8, 1'b1); check("dh_res2", res8, 16'd42);
    hold8 = 1'b0;
    @(negedge clk); check("dh_done_end", done8, 1'b0);

    // reset two cycles after do; new do on the first edge after release
    @(negedge clk); a8 = 8'd9; b8 = 8'd9; s8 = 1'b0; do8 = 1'b1;
    @(negedge clk); do8 = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("mrst_res", res8, 16'h0);
    check("mrst_done", done8, 1'b0);
    check("mrst_busy", busy8, 1'b0);
    reset = 1'b0; a8 = 8'd16; b8 = 8'd16; do8 = 1'b1;
    nd = 0;
    for (int c = 4; c <= 12; c++) begin
      @(negedge clk);
      if (done8) begin
        nd++;
        check("mrst_new_cyc", c, 8);
        check("mrst_new_res", res8, 16'h0100);
      end
      if (c == 4) do8 = 1'b0;
    end
    check("mrst_ndone", nd, 1);

    // WIDTH=2 exhaustive, both modes
    for (int sg = 0; sg < 2; sg++)
      for (int x = 0; x < 4; x++)
        for (int y = 0; y < 4; y++)
          run_op("w2", 2, x, y, sg[0], ref_mul(2, x, y, sg[0]), 3);

    // WIDTH=32 corners, then a streamed random run through a scoreboard
    run_op("w32_umax", 32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 7);
    run_op("w32_smin", 32, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 7);
    for (int c = 0; c < 10020; c++) begin
      @(negedge clk);
      if (done32) begin
        if (q.size() == 0) check("w32_extra_done", done32, 1'b0);
        else begin
          e = q.pop_front();
          check("w32_rand", res32, e);
        end
      end
      if (c < 10000) begin
        a32 = $urandom;
        b32 = $urandom;
        s32 = 1'($urandom_range(0, 1));
        do32 = 1'b1;
        q.push_back(ref_mul(32, a32, b32, s32));
      end else begin
        do32 = 1'b0;
      end
    end
    check("w32_drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
